// File: rtl/icache_dm.sv
// Direct-mapped, one-word-per-line instruction cache between IF and the memory controller.
// Optional `ICACHE_FENCE_EN adds fence_i_i, which invalidates every line.
module icache_dm #(
  parameter int unsigned INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_valid_i,
  input  logic [31:0] pc_i,
  input  logic        flush_i,
`ifdef ICACHE_FENCE_EN
  input  logic        fence_i_i,
`endif
  output logic        stall_o,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic        mc_req_o,
  output logic [31:0] mc_addr_o,
  input  logic        mc_busy_i,
  input  logic [31:0] mc_data_i
);

  localparam int unsigned TAG_BITS = 30 - INDEX_BITS;
  localparam int unsigned Lines    = 1 << INDEX_BITS;

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StLookup   = 3'd1;
  localparam logic [2:0] StMissReq  = 3'd2;
  localparam logic [2:0] StMissWait = 3'd3;
  localparam logic [2:0] StResp     = 3'd4;

  logic [2:0]          state_q, state_d;
  logic [29:0]         req_q, req_d;
  logic [31:0]         mc_addr_q, mc_addr_d;
  logic                drop_q, drop_d;
  logic                first_q, first_d;
  logic [Lines-1:0]    valid_q;
  logic [TAG_BITS-1:0] tag_mem [Lines];
  logic [31:0]         data_mem [Lines];

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   req_tag;
  logic                  hit, fill, ready, accept, fence_now, rest_state;
  logic [1:0]            unused_pc_lsb;

  assign unused_pc_lsb = pc_i[1:0];
  assign idx        = req_q[INDEX_BITS-1:0];
  assign req_tag    = req_q[29:INDEX_BITS];
  assign hit        = valid_q[idx] && (tag_mem[idx] == req_tag);
  assign rest_state = (state_q == StIdle) || (state_q == StResp);
  // Busy is ignored in the first wait cycle: the controller raises it a cycle after the pulse.
  assign fill       = (state_q == StMissWait) && !first_q && !mc_busy_i;

`ifdef ICACHE_FENCE_EN
  logic fence_pend_q, fence_pend_d;
  assign fence_now    = rest_state && (fence_i_i || fence_pend_q);
  assign fence_pend_d = fence_now ? 1'b0 : (fence_pend_q || fence_i_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fence_pend_q <= 1'b0;
    else     fence_pend_q <= fence_pend_d;
  end
`else
  assign fence_now = 1'b0;
`endif

  assign ready   = (rest_state || ((state_q == StLookup) && hit && !flush_i)) && !fence_now;
  assign stall_o = !ready;
  assign accept  = pc_valid_i && ready && !flush_i;

  always_comb begin
    state_d   = state_q;
    req_d     = accept ? pc_i[31:2] : req_q;
    mc_addr_d = mc_addr_q;
    drop_d    = drop_q;
    first_d   = 1'b0;
    case (state_q)
      StIdle, StResp: state_d = accept ? StLookup : StIdle;
      StLookup: begin
        if (flush_i) begin
          state_d = StIdle;
        end else if (hit) begin
          state_d = accept ? StLookup : StIdle;
        end else begin
          state_d   = StMissReq;
          mc_addr_d = {req_q, 2'b00};
        end
      end
      StMissReq: begin
        state_d = StMissWait;
        first_d = 1'b1;
        if (flush_i) drop_d = 1'b1;
      end
      StMissWait: begin
        if (fill) begin
          // A flush in the completion cycle also discards the response.
          state_d = (drop_q || flush_i) ? StIdle : StResp;
          drop_d  = 1'b0;
        end else if (flush_i) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      req_q     <= '0;
      mc_addr_q <= '0;
      drop_q    <= 1'b0;
      first_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      mc_addr_q <= mc_addr_d;
      drop_q    <= drop_d;
      first_q   <= first_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (fence_now) begin
      valid_q <= '0;
    end else if (fill) begin
      valid_q[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      tag_mem[idx]  <= req_tag;
      data_mem[idx] <= mc_data_i;
    end
  end

  assign inst_valid_o = (((state_q == StLookup) && hit) || (state_q == StResp)) && !flush_i;
  assign inst_o       = inst_valid_o ? data_mem[idx] : 32'h0;
  assign mc_req_o     = (state_q == StMissReq);
  assign mc_addr_o    = mc_addr_q;

endmodule
